// File: rtl/axo_regfile_sb_if.sv
// Bundle of the issue-side (read/mark) and writeback-side (write/clear) signals
// of the scoreboarded register file.
interface axo_regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
);
  localparam int IDXW = $clog2(NREGS);

  logic [NREAD*IDXW-1:0] rs_idx;
  logic [NREAD*XLEN-1:0] rs_data;
  logic [NREAD-1:0]      rs_busy;
  logic                  mark_en;
  logic [IDXW-1:0]       mark_rd;
  logic                  mark_ready;
  logic                  we;
  logic [IDXW-1:0]       rd;
  logic [XLEN-1:0]       din;
  logic                  wb_clr;
  logic                  flush;
  logic                  any_busy;

  modport master (
    output rs_idx, mark_en, mark_rd, we, rd, din, wb_clr, flush,
    input  rs_data, rs_busy, mark_ready, any_busy
  );

  modport slave (
    input  rs_idx, mark_en, mark_rd, we, rd, din, wb_clr, flush,
    output rs_data, rs_busy, mark_ready, any_busy
  );
endinterface

// File: rtl/axo_regfile_sb.sv
// Integer register file with per-register pending-write counters for RAW detection.
// Optional macro AXO_REGFILE_BYPASS_EN forwards writeback data/clear to read ports.
module axo_regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int PENDW = 2,
  localparam int IDXW = $clog2(NREGS)
) (
  input logic            clk,
  input logic            rst,
  axo_regfile_sb_if.slave bus
);

  localparam logic [PENDW-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]  regs    [NREGS];
  logic [PENDW-1:0] cnt     [NREGS];
  logic [PENDW-1:0] cnt_nxt [NREGS];
  logic             mark_acc;
  logic             any_busy;

  assign bus.mark_ready = (bus.mark_rd == '0) || (cnt[bus.mark_rd] != CNT_MAX);
  assign mark_acc       = bus.mark_en && bus.mark_ready && (bus.mark_rd != '0);

  // Coincident mark and clear on one register cancel; flush keeps only a same-cycle mark.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      logic inc;
      logic dec;
      inc = mark_acc && (bus.mark_rd == IDXW'(r));
      dec = bus.we && bus.wb_clr && (bus.rd == IDXW'(r)) && (cnt[r] != '0);
      cnt_nxt[r] = cnt[r];
      if (bus.flush)
        cnt_nxt[r] = inc ? PENDW'(1) : '0;
      else if (inc && !dec)
        cnt_nxt[r] = cnt[r] + PENDW'(1);
      else if (dec && !inc)
        cnt_nxt[r] = cnt[r] - PENDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
    end else begin
      if (bus.we && (bus.rd != '0))
        regs[bus.rd] <= bus.din;
      for (int r = 0; r < NREGS; r++)
        cnt[r] <= cnt_nxt[r];
    end
  end

  always_comb begin
    any_busy = 1'b0;
    for (int r = 1; r < NREGS; r++)
      any_busy = any_busy | (cnt[r] != '0);
  end
  assign bus.any_busy = any_busy;

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [IDXW-1:0] idx;
    logic [XLEN-1:0] data;
    logic            busy;

    assign idx = bus.rs_idx[k*IDXW +: IDXW];

    always_comb begin
      data = (idx == '0) ? '0 : regs[idx];
      busy = (idx != '0) && (cnt[idx] != '0);
`ifdef AXO_REGFILE_BYPASS_EN
      if (bus.we && (bus.rd != '0) && (bus.rd == idx)) begin
        data = bus.din;
        if (bus.wb_clr)
          busy = cnt[idx] > PENDW'(1);
      end
`endif
    end

    assign bus.rs_data[k*XLEN +: XLEN] = data;
    assign bus.rs_busy[k]              = busy;
  end

endmodule
